fifo_uart_tx: RTL and testbench
===============================

// Module: fifo_uart_tx
// PURPOSE
//   Slow-domain consumer of the Ck2CkFifo read side. Pops words from the FIFO
//   (first-word-fall-through: fifoData valid whenever fifoEmpty=0) and sends
//   each one as an asynchronous serial frame on txd:
//   start, DATA_W data bits LSB first, optional parity, stop.
//   Runs entirely in the slow clock domain; no CDC logic inside.
// PARAMETERS
//   DATA_W        8   word width; must match the FIFO DATA_W
//   CLKS_PER_BIT  16  ckSlow cycles per serial bit; legal range >= 2
//   STOP_BITS     1   number of stop bits; legal values 1 or 2
//   PARITY_EN     0   1 = append a parity bit after the data bits
//   PARITY_ODD    0   0 = even parity, 1 = odd parity; ignored if PARITY_EN=0
// PORTS
//   ckSlow     in   1       clock
//   rstSlow    in   1       synchronous, active-high reset
//   fifoData   in   DATA_W  FIFO head word, valid when fifoEmpty=0
//   fifoEmpty  in   1       FIFO empty flag
//   fifoPop    out  1       pop strobe; consumes the head word in the same cycle
//   enable     in   1       1 = allow new frames to start
//   txd        out  1       serial output; idle level is 1
//   busy       out  1       1 while a frame is in progress
//   frameDone  out  1       one-cycle pulse in the last stop-bit cycle
//   frameCnt   out  16      count of completed frames; wraps 0xFFFF -> 0
// BEHAVIOUR
//   - Reset: state=IDLE, txd=1, busy=0, fifoPop=0, frameDone=0, frameCnt=0.
//     Bit counter and cycle counter are cleared.
//   - FSM states: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE|START.
//   - Pop decision is made only in IDLE, or in the last STOP cycle.
//     Condition: enable=1 and fifoEmpty=0.
//     - fifoPop=1 for exactly that cycle. It is a Mealy output, driven from
//       state and inputs.
//     - fifoData is latched into the shift register in the same cycle.
//     - The next state is START.
//   - Timing:
//     - txd=0 starts the cycle after the pop.
//     - Every bit is held for CLKS_PER_BIT cycles.
//     - Parity bit = XOR of the data bits, inverted when PARITY_ODD=1.
//     - The stop phase is txd=1 for STOP_BITS*CLKS_PER_BIT cycles.
//   - Frame length L = (1+DATA_W+PARITY_EN+STOP_BITS)*CLKS_PER_BIT.
//     Default L = 160.
//   - frameDone=1 in the last stop cycle. frameCnt increments on that edge.
//   - Back-to-back frames:
//     - If the pop condition holds in the last stop cycle, the next START
//       follows with no idle gap and busy stays 1.
//     - Otherwise the block returns to IDLE with busy=0.
//   - busy=1 in every state except IDLE.
//   - fifoEmpty and enable are ignored mid-frame.
//     Dropping enable mid-frame lets the current frame complete but blocks
//     the next pop.
//   - Reset mid-frame: the frame is aborted and txd=1 from the next cycle.
//     The popped word is lost and no pop is issued while rstSlow=1.
//   - Counters are sized to $clog2(CLKS_PER_BIT) and $clog2(DATA_W+1) bits.
//     No overflow is possible within the legal parameter range.
// TESTING
//   1 Reset: rstSlow=1 for 3 cycles with fifoEmpty=0 and enable=1
//     -> txd=1, busy=0, fifoPop=0, frameCnt=0 during and after reset.
//   2 Single word 0xA5, defaults, pop at cycle T
//     -> txd = 0,1,0,1,0,0,1,0,1,1 with 16 cycles per bit over T+1..T+160.
//     -> frameDone at T+160; frameCnt=1; busy=0 at T+161.
//   3 FIFO preloaded with 0x00,0xFF,0x55
//     -> pops at T, T+160, T+320; txd never idles between frames.
//     -> frameCnt=3 and busy=0 at T+481.
//   4 PARITY_EN=1 with data 0x07
//     -> parity bit 1 when PARITY_ODD=0, 0 when PARITY_ODD=1; L=176.
//     STOP_BITS=2 -> stop phase lasts 32 cycles.
//   5 Assert rstSlow during data bit 3
//     -> txd=1 next cycle, busy=0, frameCnt=0.
//     -> The next pop occurs only in the first cycle with rstSlow=0.
//   6 enable=0 with fifoEmpty=0 -> no pop for 100 cycles.
//     Drop enable during a frame -> the frame completes and no further pop.
//     frameCnt at 0xFFFF plus one frame -> frameCnt=0x0000.

Source files
------------

// File: rtl/fifo_uart_tx.sv
// Serial transmitter draining a first-word-fall-through FIFO.
// Frame: start, DATA_W bits LSB first, optional parity, STOP_BITS stops.
module fifo_uart_tx #(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0
) (
  input  logic              ckSlow,
  input  logic              rstSlow,
  input  logic [DATA_W-1:0] fifoData,
  input  logic              fifoEmpty,
  output logic              fifoPop,
  input  logic              enable,
  output logic              txd,
  output logic              busy,
  output logic              frameDone,
  output logic [15:0]       frameCnt
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_W + 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] DATA_LAST = BW'(DATA_W - 1);
  localparam logic [BW-1:0] STOP_LAST = BW'(STOP_BITS - 1);
  localparam logic          ODD       = (PARITY_ODD != 0);

  typedef enum logic [2:0] {
    IDLE, START, DATA, PARITY, STOP
  } state_t;

  state_t            state;
  state_t            state_nx;
  logic [CW-1:0]     clk_cnt;
  logic [BW-1:0]     bit_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic [15:0]       frame_cnt;
  logic              bit_end;
  logic              last_stop;
  logic              load;

  assign bit_end   = (clk_cnt == CNT_MAX);
  assign last_stop = (state == STOP) && bit_end &&
                     (bit_cnt == STOP_LAST);
  // A pop is only legal between frames, never while in reset
  assign load = enable && !fifoEmpty && !rstSlow &&
                ((state == IDLE) || last_stop);

  always_ff @(posedge ckSlow) begin
    if (rstSlow) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (load) state_nx = START;
      START:  if (bit_end) state_nx = DATA;
      DATA:
        if (bit_end && (bit_cnt == DATA_LAST))
          state_nx = (PARITY_EN != 0) ? PARITY : STOP;
      PARITY: if (bit_end) state_nx = STOP;
      STOP:
        if (last_stop)
          state_nx = load ? START : IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge ckSlow) begin
    if (rstSlow) begin
      clk_cnt   <= '0;
      bit_cnt   <= '0;
      shreg     <= '0;
      par_bit   <= 1'b0;
      frame_cnt <= '0;
    end else begin
      if ((state == IDLE) || bit_end) clk_cnt <= '0;
      else clk_cnt <= clk_cnt + 1'b1;
      // bit_cnt indexes data bits in DATA and stop bits in STOP
      if (state_nx != state) bit_cnt <= '0;
      else if (bit_end)      bit_cnt <= bit_cnt + 1'b1;
      if (load) begin
        shreg   <= fifoData;
        par_bit <= (^fifoData) ^ ODD;
      end else if ((state == DATA) && bit_end) begin
        shreg <= shreg >> 1;
      end
      if (last_stop) frame_cnt <= frame_cnt + 1'b1;
    end
  end

  always_comb begin
    txd = 1'b1;
    unique case (state)
      IDLE:    txd = 1'b1;
      START:   txd = 1'b0;
      DATA:    txd = shreg[0];
      PARITY:  txd = par_bit;
      STOP:    txd = 1'b1;
      default: txd = 1'b1;
    endcase
    busy      = (state != IDLE);
    fifoPop   = load;
    frameDone = last_stop;
    frameCnt  = frame_cnt;
  end

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Scoreboard bench: three transmitter configurations fed by queue FIFOs.
// A per-DUT monitor checks every txd cycle against the queued frame.
module tb_fifo_uart_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [2:0]  en;
  logic [2:0]  empty;
  logic [2:0]  pop;
  logic [2:0]  txd;
  logic [2:0]  busy;
  logic [2:0]  done;
  logic [7:0]  fd [3];
  logic [15:0] fc [3];

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  logic [7:0]  fq    [3][$];
  logic [11:0] expq  [3][$];
  int          popcyc[3][$];
  int          donecyc[3][$];
  int          npop  [3];
  logic [15:0] cnt_m [3];
  bit          pend  [3];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  fifo_uart_tx u0 (
    .ckSlow(clk), .rstSlow(rst), .fifoData(fd[0]),
    .fifoEmpty(empty[0]), .fifoPop(pop[0]), .enable(en[0]),
    .txd(txd[0]), .busy(busy[0]), .frameDone(done[0]),
    .frameCnt(fc[0]));

  fifo_uart_tx #(.STOP_BITS(2), .PARITY_EN(1), .PARITY_ODD(0)) u1 (
    .ckSlow(clk), .rstSlow(rst), .fifoData(fd[1]),
    .fifoEmpty(empty[1]), .fifoPop(pop[1]), .enable(en[1]),
    .txd(txd[1]), .busy(busy[1]), .frameDone(done[1]),
    .frameCnt(fc[1]));

  fifo_uart_tx #(.STOP_BITS(1), .PARITY_EN(1), .PARITY_ODD(1)) u2 (
    .ckSlow(clk), .rstSlow(rst), .fifoData(fd[2]),
    .fifoEmpty(empty[2]), .fifoPop(pop[2]), .enable(en[2]),
    .txd(txd[2]), .busy(busy[2]), .frameDone(done[2]),
    .frameCnt(fc[2]));

  localparam int LEN [3] = '{160, 192, 176};

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s @cyc %0d: got %0h expected %0h",
               name, cyc, act, exp);
    end
  endtask

  task automatic refresh(input int g);
    empty[g] = (fq[g].size() == 0);
    fd[g]    = (fq[g].size() != 0) ? fq[g][0] : 8'h00;
  endtask

  task automatic push(input int g, input logic [7:0] d,
                      input logic [11:0] e);
    fq[g].push_back(d);
    expq[g].push_back(e);
    refresh(g);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_cyc(input int c);
    while (cyc < c) step();
  endtask

  task automatic wait_pop(input int g, output int t);
    int n0 = npop[g];
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      step();
      got = (npop[g] > n0);
    end
    chk($sformatf("pop_seen%0d", g), int'(got), 1);
    t = got ? popcyc[g][$] : cyc;
  endtask

  for (genvar g = 0; g < 3; g++) begin : g_dev
    // The popped head leaves the model FIFO just after the edge
    always @(posedge clk) begin
      #1;
      if (pend[g] && fq[g].size() != 0) void'(fq[g].pop_front());
      pend[g] = 1'b0;
      refresh(g);
    end

    int          pos = -1;
    bit          prev_rst = 1'b0;
    logic [11:0] cur = '0;

    always @(negedge clk) begin
      if (rst) begin
        chk($sformatf("pop_in_rst%0d", g), int'(pop[g]), 0);
        if (prev_rst) begin
          chk($sformatf("rst_txd%0d", g), int'(txd[g]), 1);
          chk($sformatf("rst_busy%0d", g), int'(busy[g]), 0);
          chk($sformatf("rst_cnt%0d", g), int'(fc[g]), 0);
        end
        pos      = -1;
        cnt_m[g] = '0;
        pend[g]  = 1'b0;
        prev_rst = 1'b1;
      end else begin
        prev_rst = 1'b0;
        if (pos >= 0) begin
          chk($sformatf("txd%0d_p%0d", g, pos), int'(txd[g]),
              int'(cur[pos/16]));
          chk($sformatf("busy%0d", g), int'(busy[g]), 1);
          chk($sformatf("done%0d", g), int'(done[g]),
              int'(pos == LEN[g] - 1));
        end else begin
          chk($sformatf("idle_txd%0d", g), int'(txd[g]), 1);
          chk($sformatf("idle_busy%0d", g), int'(busy[g]), 0);
          chk($sformatf("idle_done%0d", g), int'(done[g]), 0);
        end
        chk($sformatf("cnt%0d", g), int'(fc[g]), int'(cnt_m[g]));
        if (pos == LEN[g] - 1) begin
          cnt_m[g] = cnt_m[g] + 16'd1;
          donecyc[g].push_back(cyc);
          pos = -1;
        end else if (pos >= 0) begin
          pos++;
        end
        pend[g] = pop[g];
        if (pop[g]) begin
          npop[g]++;
          popcyc[g].push_back(cyc);
          chk($sformatf("pop_overlap%0d", g), pos, -1);
          chk($sformatf("pop_expected%0d", g),
              int'(expq[g].size() != 0), 1);
          if (expq[g].size() != 0) begin
            cur = expq[g].pop_front();
            pos = 0;
          end
        end
      end
    end
  end

  int t;
  int t2;
  int n0;

  initial begin
    rst = 1'b1;
    en  = 3'b000;
    for (int g = 0; g < 3; g++) begin
      npop[g]  = 0;
      cnt_m[g] = '0;
      pend[g]  = 1'b0;
      refresh(g);
    end

    // Reset with a word waiting and enable high
    push(0, 8'hA5, {3'b000, 1'b1, 8'hA5, 1'b0});
    en[0] = 1'b1;
    repeat (3) step();
    chk("rst_txd", int'(txd[0]), 1);
    chk("rst_busy", int'(busy[0]), 0);
    chk("rst_cnt", int'(fc[0]), 0);
    chk("rst_nopop", npop[0], 0);
    rst = 1'b0;

    // Single 0xA5 frame
    wait_pop(0, t);
    wait_cyc(t + 161);
    chk("a5_len", donecyc[0][$] - t, 160);
    chk("a5_busy", int'(busy[0]), 0);
    chk("a5_cnt", int'(fc[0]), 1);

    // Three preloaded words back to back
    rst = 1'b1;
    step();
    rst = 1'b0;
    en[0] = 1'b0;
    push(0, 8'h00, {3'b000, 1'b1, 8'h00, 1'b0});
    push(0, 8'hFF, {3'b000, 1'b1, 8'hFF, 1'b0});
    push(0, 8'h55, {3'b000, 1'b1, 8'h55, 1'b0});
    en[0] = 1'b1;
    wait_pop(0, t);
    wait_cyc(t + 481);
    chk("b2b_pop2", popcyc[0][$-1] - t, 160);
    chk("b2b_pop3", popcyc[0][$] - t, 320);
    chk("b2b_busy", int'(busy[0]), 0);
    chk("b2b_cnt", int'(fc[0]), 3);
    en[0] = 1'b0;

    // Parity: even with two stops, odd with one stop
    push(1, 8'h07, {2'b11, 1'b1, 8'h07, 1'b0});
    push(1, 8'h03, {2'b11, 1'b0, 8'h03, 1'b0});
    push(2, 8'h07, {2'b01, 1'b0, 8'h07, 1'b0});
    push(2, 8'h03, {2'b01, 1'b1, 8'h03, 1'b0});
    en[2:1] = 2'b11;
    wait_pop(1, t);
    wait_cyc(t + 2 * 192 + 2);
    chk("par_even_len", donecyc[1][0] - popcyc[1][0], 192);
    chk("par_even_gap", popcyc[1][1] - popcyc[1][0], 192);
    chk("par_odd_len", donecyc[2][0] - popcyc[2][0], 176);
    chk("par_odd_gap", popcyc[2][1] - popcyc[2][0], 176);
    chk("par_even_cnt", int'(fc[1]), 2);
    chk("par_odd_cnt", int'(fc[2]), 2);

    // Reset during data bit 3
    en[0] = 1'b1;
    push(0, 8'hA5, {3'b000, 1'b1, 8'hA5, 1'b0});
    wait_pop(0, t);
    push(0, 8'h3C, {3'b000, 1'b1, 8'h3C, 1'b0});
    wait_cyc(t + 70);
    rst = 1'b1;
    step();
    chk("abort_txd", int'(txd[0]), 1);
    chk("abort_busy", int'(busy[0]), 0);
    chk("abort_cnt", int'(fc[0]), 0);
    step();
    step();
    rst = 1'b0;
    wait_pop(0, t2);
    chk("abort_repop", t2 - t, 73);
    wait_cyc(t2 + 162);
    chk("abort_cnt2", int'(fc[0]), 1);

    // enable low blocks pops; dropping it mid-frame ends the stream
    en[0] = 1'b0;
    push(0, 8'h11, {3'b000, 1'b1, 8'h11, 1'b0});
    n0 = npop[0];
    repeat (100) step();
    chk("dis_nopop", npop[0], n0);
    en[0] = 1'b1;
    wait_pop(0, t);
    repeat (20) step();
    en[0] = 1'b0;
    push(0, 8'h22, {3'b000, 1'b1, 8'h22, 1'b0});
    wait_cyc(t + 200);
    chk("drop_pops", npop[0], n0 + 1);
    chk("drop_busy", int'(busy[0]), 0);
    chk("drop_cnt", int'(fc[0]), 2);

    // Counter wrap from 0xFFFF
    force u0.frame_cnt = 16'hFFFF;
    cnt_m[0] = 16'hFFFF;
    #1;
    release u0.frame_cnt;
    chk("wrap_pre", int'(fc[0]), 16'hFFFF);
    en[0] = 1'b1;
    wait_pop(0, t);
    wait_cyc(t + 162);
    chk("wrap_cnt", int'(fc[0]), 0);

    for (int g = 0; g < 3; g++)
      chk($sformatf("drained%0d", g), expq[g].size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
